// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES equal chunks,
// one chunk per register stage, with optional signed saturation and a sticky overflow flag.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    localparam int MSB  = WIDTH - 1;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cy_q, cy_d;
    logic [STAGES-1:0] sat_q, sat_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  bx_q  [STAGES];
    logic [WIDTH-1:0]  bx_d  [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic              ovf_sticky_q, ovf_sticky_d;
    logic              adv;
    logic              ovf_raw;

    function automatic logic [CW:0] chunk_add(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                              input logic c);
        return {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, c};
    endfunction

    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw, input logic neg,
                                                  input logic clip);
        logic [WIDTH-1:0] lim;
        lim = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return clip ? lim : raw;
    endfunction

    // Global stall: nothing moves while the last stage holds an unaccepted result.
    assign adv      = !(vld_q[LAST] && !out_ready);
    assign in_ready = adv;

    // Operands travel whole with each slot; stage s only consumes chunk s, so the
    // upper chunks are effectively skew-delayed and the lower result chunks deskewed.
    always_comb begin
        logic [CW:0] t;
        vld_d[0] = in_valid;
        a_d[0]   = a;
        bx_d[0]  = sub ? ~b : b;
        sat_d[0] = sat;
        t        = chunk_add(a[CW-1:0], bx_d[0][CW-1:0], sub ? ~cin : cin);
        res_d[0] = '0;
        res_d[0][CW-1:0] = t[CW-1:0];
        cy_d[0]  = t[CW];
        for (int s = 1; s < STAGES; s++) begin
            vld_d[s] = vld_q[s-1];
            a_d[s]   = a_q[s-1];
            bx_d[s]  = bx_q[s-1];
            sat_d[s] = sat_q[s-1];
            t        = chunk_add(a_q[s-1][s*CW +: CW], bx_q[s-1][s*CW +: CW], cy_q[s-1]);
            res_d[s] = res_q[s-1];
            res_d[s][s*CW +: CW] = t[CW-1:0];
            cy_d[s]  = t[CW];
        end
    end

    assign ovf_raw   = (a_q[LAST][MSB] == bx_q[LAST][MSB]) && (res_q[LAST][MSB] != a_q[LAST][MSB]);
    assign out_valid = vld_q[LAST];
    assign ovf       = out_valid && ovf_raw;
    assign cout      = out_valid && cy_q[LAST];
    assign sum       = out_valid ? saturate(res_q[LAST], a_q[LAST][MSB], sat_q[LAST] && ovf_raw)
                                 : '0;

    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (clr_sticky) ovf_sticky_d = 1'b0;
        if (out_valid && out_ready && ovf) ovf_sticky_d = 1'b1;
    end

    assign ovf_sticky = ovf_sticky_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q        <= '0;
            ovf_sticky_q <= 1'b0;
        end else begin
            if (adv) vld_q <= vld_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    // Datapath registers carry no reset; an invalid slot's contents are never observed.
    always_ff @(posedge clk) begin
        if (adv) begin
            a_q   <= a_d;
            bx_q  <= bx_d;
            res_q <= res_d;
            cy_q  <= cy_d;
            sat_q <= sat_d;
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed checks of pipe_adder (WIDTH=8, STAGES=2) plus a random scoreboard run
// on three instances with STAGES = 1, 2 and 8.
module tb_pipe_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       cin = 1'b0, sub = 1'b0, sat = 1'b0, clr_sticky = 1'b0;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic       mon_en = 1'b0;

    logic [2:0] rdy_w, ov_w, co_w, of_w, st_w;
    logic [7:0] sum_w [3];

    int tests_run = 0;
    int failed    = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] ref_add(input logic [7:0] xa, input logic [7:0] xb,
                                           input logic xc, input logic xs, input logic xsat);
        logic [7:0] bx;
        logic       c;
        logic [8:0] t;
        logic       o;
        logic [7:0] s;
        bx = xs ? ~xb : xb;
        c  = xs ? ~xc : xc;
        t  = {1'b0, xa} + {1'b0, bx} + {8'b0, c};
        o  = (xa[7] == bx[7]) && (t[7] != xa[7]);
        s  = (xsat && o) ? (xa[7] ? 8'h80 : 8'h7F) : t[7:0];
        return {t[8], o, s};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int ST = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
        logic [9:0] exp_q[$];
        int n_push = 0;
        int n_pop  = 0;

        pipe_adder #(.WIDTH(8), .STAGES(ST)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (rdy_w[g]),
            .a          (a),
            .b          (b),
            .cin        (cin),
            .sub        (sub),
            .sat        (sat),
            .out_valid  (ov_w[g]),
            .out_ready  (out_ready),
            .sum        (sum_w[g]),
            .cout       (co_w[g]),
            .ovf        (of_w[g]),
            .ovf_sticky (st_w[g]),
            .clr_sticky (clr_sticky)
        );

        always @(negedge clk) begin
            if (mon_en) begin
                if (in_valid && rdy_w[g]) begin
                    exp_q.push_back(ref_add(a, b, cin, sub, sat));
                    n_push++;
                end
                if (ov_w[g] && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("rnd_s%0d_extra", ST), 32'd1, 32'd0);
                    end else begin
                        check($sformatf("rnd_s%0d_res", ST),
                              32'({co_w[g], of_w[g], sum_w[g]}), 32'(exp_q.pop_front()));
                        n_pop++;
                    end
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                         input logic xs, input logic xsat);
        a = xa; b = xb; cin = xc; sub = xs; sat = xsat; in_valid = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        rst = 1'b1;
        step;
        check("rst_in_ready", 32'(rdy_w[1]), 'h1);
        step;
        rst = 1'b0;
        check("rst_out_valid", 32'(ov_w[1]), 'h0);
        check("rst_outputs", 32'({sum_w[1], co_w[1], of_w[1]}), 'h0);
        check("rst_sticky", 32'(st_w[1]), 'h0);

        // FF + 01 wraps with carry-out
        drive(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        step; in_valid = 1'b0;
        check("t1_not_yet", 32'(ov_w[1]), 'h0);
        step;
        check("t1_valid", 32'(ov_w[1]), 'h1);
        check("t1_sum", 32'(sum_w[1]), 'h00);
        check("t1_cout", 32'(co_w[1]), 'h1);
        check("t1_ovf", 32'(of_w[1]), 'h0);
        step;
        check("t1_sticky", 32'(st_w[1]), 'h0);

        // 7F + 01 overflows: wrapped, then saturated
        drive(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        step; in_valid = 1'b0; step;
        check("t2_sum_wrap", 32'(sum_w[1]), 'h80);
        check("t2_ovf_wrap", 32'(of_w[1]), 'h1);
        step;
        check("t2_sticky_set", 32'(st_w[1]), 'h1);
        drive(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
        step; in_valid = 1'b0; step;
        check("t2_sum_sat", 32'(sum_w[1]), 'h7F);
        check("t2_ovf_sat", 32'(of_w[1]), 'h1);
        check("t2_cout_sat", 32'(co_w[1]), 'h0);
        clr_sticky = 1'b1;
        step;
        check("t2_set_wins", 32'(st_w[1]), 'h1);
        step;
        check("t2_sticky_clr", 32'(st_w[1]), 'h0);
        clr_sticky = 1'b0;

        // subtraction
        drive(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
        step; in_valid = 1'b0; step;
        check("t3_sub", 32'({co_w[1], of_w[1], sum_w[1]}), 'h0FE);
        drive(8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
        step; in_valid = 1'b0; step;
        check("t3_sub_sat", 32'({co_w[1], of_w[1], sum_w[1]}), 'h380);
        step; step;

        // back-to-back with a 3-cycle downstream stall
        out_ready = 1'b0;
        drive(8'h01, 8'h01, 1'b0, 1'b0, 1'b0); step;
        drive(8'h02, 8'h02, 1'b0, 1'b0, 1'b0); step;
        check("t4_stall_rdy0", 32'(rdy_w[1]), 'h0);
        check("t4_first", 32'(sum_w[1]), 'h02);
        drive(8'h03, 8'h03, 1'b0, 1'b0, 1'b0); step;
        check("t4_stall_rdy1", 32'(rdy_w[1]), 'h0);
        check("t4_hold1", 32'(sum_w[1]), 'h02);
        step;
        check("t4_stall_rdy2", 32'(rdy_w[1]), 'h0);
        check("t4_hold2", 32'({ov_w[1], sum_w[1]}), 'h102);
        out_ready = 1'b1;
        step;
        drive(8'h04, 8'h04, 1'b0, 1'b0, 1'b0);
        check("t4_second", 32'({ov_w[1], sum_w[1]}), 'h104);
        step; in_valid = 1'b0;
        check("t4_third", 32'({ov_w[1], sum_w[1]}), 'h106);
        step;
        check("t4_fourth", 32'({ov_w[1], sum_w[1]}), 'h108);
        step;
        check("t4_drained", 32'(ov_w[1]), 'h0);

        // reset with two transactions in flight
        out_ready = 1'b0;
        drive(8'h11, 8'h11, 1'b0, 1'b0, 1'b0); step;
        drive(8'h22, 8'h22, 1'b0, 1'b0, 1'b0); step;
        in_valid = 1'b0;
        rst = 1'b1;
        step;
        check("t5_rst_valid", 32'(ov_w[1]), 'h0);
        check("t5_rst_ready", 32'(rdy_w[1]), 'h1);
        rst = 1'b0; out_ready = 1'b1;
        step;
        check("t5_gone1", 32'(ov_w[1]), 'h0);
        step;
        check("t5_gone2", 32'(ov_w[1]), 'h0);
        drive(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
        step; in_valid = 1'b0; step;
        check("t5_fresh", 32'({ov_w[1], sum_w[1]}), 'h130);
        step;

        // random traffic against the reference model on all three depths
        rst = 1'b1; step; rst = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            cin = 1'($urandom); sub = 1'($urandom); sat = 1'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) step;
        mon_en = 1'b0;
        check("rnd_s1_count", 32'(g_dut[0].n_pop), 32'(g_dut[0].n_push));
        check("rnd_s2_count", 32'(g_dut[1].n_pop), 32'(g_dut[1].n_push));
        check("rnd_s8_count", 32'(g_dut[2].n_pop), 32'(g_dut[2].n_push));
        check("rnd_s1_active", 32'(g_dut[0].n_push > 100), 'h1);
        check("rnd_s8_active", 32'(g_dut[2].n_push > 100), 'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
